// File: rtl/wbrd2axil_master.sv
// Read-only pipelined Wishbone slave to AXI-lite AR/R master bridge.
// Responses return in order; a bus error or a dropped cycle flushes the remaining replies.
module wbrd2axil_master #(
    parameter int         C_AXI_DATA_WIDTH = 32,
    parameter int         C_AXI_ADDR_WIDTH = 28,
    parameter int         AXILLSB          = $clog2(C_AXI_DATA_WIDTH / 8),
    parameter int         LGFIFO           = 3,
    parameter logic [2:0] OPT_PROT         = 3'b000,
    localparam int        AW               = C_AXI_ADDR_WIDTH - AXILLSB
) (
    input  logic                            i_clk,
    input  logic                            i_axi_reset_n,
    input  logic                            i_wb_cyc,
    input  logic                            i_wb_stb,
    input  logic                            i_wb_we,
    input  logic [AW-1:0]                   i_wb_addr,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                            o_wb_stall,
    output logic                            o_wb_ack,
    output logic [C_AXI_DATA_WIDTH-1:0]     o_wb_data,
    output logic                            o_wb_err,
    output logic                            o_axi_arvalid,
    input  logic                            i_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0]     o_axi_araddr,
    output logic [2:0]                      o_axi_arprot,
    input  logic                            i_axi_rvalid,
    output logic                            o_axi_rready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     i_axi_rdata,
    input  logic [1:0]                      i_axi_rresp
);

    localparam int             CW        = LGFIFO + 1;
    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_FULL  = {1'b1, {LGFIFO{1'b0}}};

    // SLVERR and DECERR both have the upper response bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] outstanding_nxt_s;
    logic          flushing_r;
    logic          flushing_nxt_s;
    logic          stall_s;
    logic          accept_s;
    logic          rd_accept_s;
    logic          wr_accept_s;
    logic          r_live_s;
    logic          r_ok_s;
    logic          r_err_s;
    logic          unused_s;

    assign o_axi_rready = 1'b1;
    assign o_axi_arprot = OPT_PROT;
    assign o_wb_stall   = stall_s;
    assign unused_s     = ^{i_wb_sel, i_axi_rresp[0]};

    // Stall, request acceptance and response classification.
    always_comb begin
        stall_s = flushing_r
               || (o_axi_arvalid && !i_axi_arready)
               || (outstanding_r == CNT_FULL)
               || (i_wb_we && (outstanding_r != CNT_ZERO))
               || !i_wb_cyc;
        accept_s    = i_wb_stb && !stall_s;
        rd_accept_s = accept_s && !i_wb_we;
        wr_accept_s = accept_s && i_wb_we;
        r_live_s    = i_axi_rvalid && !flushing_r && i_wb_cyc;
        r_ok_s      = r_live_s && !resp_is_err(i_axi_rresp);
        r_err_s     = r_live_s && resp_is_err(i_axi_rresp);
    end

    // Next outstanding count and flush state; flushing ends the cycle the count reaches zero.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        if (rd_accept_s && !i_axi_rvalid) begin
            outstanding_nxt_s = outstanding_r + CNT_ONE;
        end else if (!rd_accept_s && i_axi_rvalid && (outstanding_r != CNT_ZERO)) begin
            outstanding_nxt_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end

        flushing_nxt_s = 1'b0;
        if (flushing_r) begin
            flushing_nxt_s = (outstanding_nxt_s != CNT_ZERO);
        end else if (r_err_s || !i_wb_cyc) begin
            flushing_nxt_s = (outstanding_nxt_s != CNT_ZERO);
        end else begin
            flushing_nxt_s = 1'b0;
        end
    end

    // Outstanding-read bookkeeping.
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            outstanding_r <= CNT_ZERO;
            flushing_r    <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            flushing_r    <= flushing_nxt_s;
        end
    end

    // AR channel: a new accept may replace a beat in the same cycle it handshakes.
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            o_axi_arvalid <= 1'b0;
            o_axi_araddr  <= {C_AXI_ADDR_WIDTH{1'b0}};
        end else if (rd_accept_s) begin
            o_axi_arvalid <= 1'b1;
            o_axi_araddr  <= C_AXI_ADDR_WIDTH'(i_wb_addr) << AXILLSB;
        end else if (i_axi_arready) begin
            o_axi_arvalid <= 1'b0;
        end
    end

    // WB response pulses; writes are refused with an error.
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_data <= {C_AXI_DATA_WIDTH{1'b0}};
        end else begin
            o_wb_ack <= r_ok_s;
            o_wb_err <= r_err_s || wr_accept_s;
            if (r_ok_s) begin
                o_wb_data <= i_axi_rdata;
            end
        end
    end

endmodule

// File: tb/tb_wbrd2axil_master.sv
// Directed bench for wbrd2axil_master: reads, back-pressure, errors, flushes, writes and reset.
module tb_wbrd2axil_master;

    logic        i_clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [25:0] addr;
    logic [3:0]  sel;
    logic        stall, ack, err;
    logic [31:0] wdata;
    logic        arvalid, arready;
    logic [27:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    wbrd2axil_master dut (
        .i_clk(i_clk), .i_axi_reset_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(wdata), .o_wb_err(err),
        .o_axi_arvalid(arvalid), .i_axi_arready(arready), .o_axi_araddr(araddr),
        .o_axi_arprot(arprot), .i_axi_rvalid(rvalid), .o_axi_rready(rready),
        .i_axi_rdata(rdata), .i_axi_rresp(rresp)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rbeat(input logic [31:0] d, input logic [1:0] r);
        rvalid = 1'b1; rdata = d; rresp = r;
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 26'h0; sel = 4'hF;
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        #2;
        n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        n_cmp++; if (ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_ackerr: got %b%b want 00", ack, err); end
        n_cmp++; if (wdata !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", wdata); end
        n_cmp++; if (araddr !== 28'h0) begin n_bad++; $display("FAIL reset_araddr: got %h want 0", araddr); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", stall); end
        n_cmp++; if (rready !== 1'b1 || arprot !== 3'b000) begin n_bad++; $display("FAIL reset_ties: got %b/%b want 1/000", rready, arprot); end
        n_cmp++; if (dut.outstanding_r !== 4'd0 || dut.flushing_r !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %0d/%b want 0/0", dut.outstanding_r, dut.flushing_r); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        cyc = 1'b1; we = 1'b0; arready = 1'b1; stb = 1'b1; addr = 26'h10;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL single_stall: got %b want 0", stall); end
        tick();
        stb = 1'b0;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 28'h40) begin n_bad++; $display("FAIL single_ar: got %b/%h want 1/40", arvalid, araddr); end
        tick();
        n_cmp++; if (arvalid !== 1'b0 || ack !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b/%b want 0/0", arvalid, ack); end
        rbeat(32'hDEADBEEF, 2'b00);
        n_cmp++; if (ack !== 1'b1 || wdata !== 32'hDEADBEEF || err !== 1'b0) begin n_bad++; $display("FAIL single_ack: got %b/%h/%b want 1/deadbeef/0", ack, wdata, err); end
        tick();
        n_cmp++; if (ack !== 1'b0 || dut.outstanding_r !== 4'd0) begin n_bad++; $display("FAIL single_done: got %b/%0d want 0/0", ack, dut.outstanding_r); end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int ar = 0;
        logic st, arv;
        logic [27:0] ara, exp_a;
        stb = 1'b1;
        for (int c = 0; c < 14; c++) begin
            addr = 26'h100 + 26'(acc);
            #1;
            st = stall; arv = arvalid; ara = araddr;
            tick();
            if (!st) acc++;
            if (arv) begin
                exp_a = 28'h400 + 28'(ar * 4);
                n_cmp++; if (ara !== exp_a) begin n_bad++; $display("FAIL b2b_araddr: got %h want %h", ara, exp_a); end
                ar++;
            end
        end
        n_cmp++; if (acc !== 8 || ar !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d/%0d want 8/8", acc, ar); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_full_stall: got %b want 1", stall); end
        stb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rbeat(32'hA000_0000 + 32'(k), 2'b00);
            n_cmp++; if (ack !== 1'b1 || wdata !== 32'hA000_0000 + 32'(k)) begin n_bad++; $display("FAIL b2b_ack: got %b/%h want 1/%h", ack, wdata, 32'hA000_0000 + 32'(k)); end
        end
        tick();
        n_cmp++; if (ack !== 1'b0 || dut.outstanding_r !== 4'd0) begin n_bad++; $display("FAIL b2b_drained: got %b/%0d want 0/0", ack, dut.outstanding_r); end
        stb = 1'b1; addr = 26'h108;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_resume_stall: got %b want 0", stall); end
        tick();
        addr = 26'h109;
        n_cmp++; if (araddr !== 28'h420) begin n_bad++; $display("FAIL b2b_ar9: got %h want 420", araddr); end
        tick();
        stb = 1'b0;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 28'h424) begin n_bad++; $display("FAIL b2b_ar10: got %b/%h want 1/424", arvalid, araddr); end
        tick();
        n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_ar_clear: got %b want 0", arvalid); end
        rbeat(32'hB000_0000, 2'b00);
        rbeat(32'hB000_0001, 2'b00);
        n_cmp++; if (ack !== 1'b1 || wdata !== 32'hB000_0001) begin n_bad++; $display("FAIL b2b_last_ack: got %b/%h want 1/b0000001", ack, wdata); end
        tick();
    endtask

    task automatic test_ar_backpressure();
        arready = 1'b0; stb = 1'b1; addr = 26'h55;
        tick();
        addr = 26'h66;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (arvalid !== 1'b1 || araddr !== 28'h154 || stall !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %b/%h/%b want 1/154/1", arvalid, araddr, stall); end
            tick();
        end
        arready = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", stall); end
        tick();
        stb = 1'b0;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 28'h198) begin n_bad++; $display("FAIL bp_next_ar: got %b/%h want 1/198", arvalid, araddr); end
        tick();
        n_cmp++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL bp_clear: got %b want 0", arvalid); end
        rbeat(32'hC000_0000, 2'b00);
        rbeat(32'hC000_0001, 2'b00);
        n_cmp++; if (ack !== 1'b1 || wdata !== 32'hC000_0001) begin n_bad++; $display("FAIL bp_ack: got %b/%h want 1/c0000001", ack, wdata); end
        tick();
    endtask

    task automatic test_error_flush();
        stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 26'h20 + 26'(i);
            tick();
        end
        stb = 1'b0;
        tick();
        rbeat(32'h1111_1111, 2'b00);
        n_cmp++; if (ack !== 1'b1 || err !== 1'b0 || wdata !== 32'h1111_1111) begin n_bad++; $display("FAIL err_beat1: got %b/%b/%h want 1/0/11111111", ack, err, wdata); end
        rbeat(32'h2222_2222, 2'b10);
        n_cmp++; if (ack !== 1'b0 || err !== 1'b1 || stall !== 1'b1) begin n_bad++; $display("FAIL err_beat2: got %b/%b/%b want 0/1/1", ack, err, stall); end
        rbeat(32'h3333_3333, 2'b00);
        n_cmp++; if (ack !== 1'b0 || err !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL err_beat3: got %b/%b/%b want 0/0/1", ack, err, stall); end
        rbeat(32'h4444_4444, 2'b00);
        n_cmp++; if (ack !== 1'b0 || err !== 1'b0 || stall !== 1'b0 || wdata !== 32'h1111_1111) begin n_bad++; $display("FAIL err_beat4: got %b/%b/%b/%h want 0/0/0/11111111", ack, err, stall, wdata); end
        stb = 1'b1; addr = 26'h30;
        tick();
        stb = 1'b0;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 28'hC0) begin n_bad++; $display("FAIL err_new_ar: got %b/%h want 1/c0", arvalid, araddr); end
        tick();
        rbeat(32'h5555_5555, 2'b00);
        n_cmp++; if (ack !== 1'b1 || wdata !== 32'h5555_5555) begin n_bad++; $display("FAIL err_new_ack: got %b/%h want 1/55555555", ack, wdata); end
        tick();
    endtask

    task automatic test_cyc_drop();
        stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 26'h40 + 26'(i);
            tick();
        end
        stb = 1'b0;
        tick();
        cyc = 1'b0;
        tick();
        n_cmp++; if (dut.flushing_r !== 1'b1 || stall !== 1'b1) begin n_bad++; $display("FAIL drop_enter: got %b/%b want 1/1", dut.flushing_r, stall); end
        cyc = 1'b1; stb = 1'b1; addr = 26'h50;
        for (int k = 0; k < 3; k++) begin
            rbeat(32'hD000_0000 + 32'(k), 2'b00);
            n_cmp++; if (ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL drop_noack: got %b/%b want 0/0", ack, err); end
            if (k < 2) begin
                n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL drop_stall: got %b want 1", stall); end
            end else begin
                n_cmp++; if (stall !== 1'b0 || dut.flushing_r !== 1'b0) begin n_bad++; $display("FAIL drop_exit: got %b/%b want 0/0", stall, dut.flushing_r); end
            end
        end
        tick();
        stb = 1'b0;
        n_cmp++; if (arvalid !== 1'b1 || araddr !== 28'h140) begin n_bad++; $display("FAIL drop_new_ar: got %b/%h want 1/140", arvalid, araddr); end
        tick();
        rbeat(32'hE000_0000, 2'b00);
        n_cmp++; if (ack !== 1'b1 || wdata !== 32'hE000_0000) begin n_bad++; $display("FAIL drop_new_ack: got %b/%h want 1/e0000000", ack, wdata); end
        tick();
    endtask

    task automatic test_write_err();
        we = 1'b1; stb = 1'b1; addr = 26'h77;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL wr_stall: got %b want 0", stall); end
        tick();
        stb = 1'b0; we = 1'b0;
        n_cmp++; if (err !== 1'b1 || ack !== 1'b0 || arvalid !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b/%b/%b want 1/0/0", err, ack, arvalid); end
        tick();
        n_cmp++; if (err !== 1'b0 || arvalid !== 1'b0) begin n_bad++; $display("FAIL wr_pulse: got %b/%b want 0/0", err, arvalid); end
        stb = 1'b1; addr = 26'h78;
        tick();
        we = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL wr_busy_stall: got %b want 1", stall); end
        stb = 1'b0; we = 1'b0;
        tick();
        rbeat(32'hF000_0000, 2'b00);
        n_cmp++; if (ack !== 1'b1 || wdata !== 32'hF000_0000) begin n_bad++; $display("FAIL wr_read_ack: got %b/%h want 1/f0000000", ack, wdata); end
        tick();
    endtask

    task automatic test_reset_midburst();
        arready = 1'b1; stb = 1'b1; addr = 26'h60;
        tick();
        addr = 26'h61;
        tick();
        stb = 1'b0; arready = 1'b0;
        rbeat(32'h5A5A_5A5A, 2'b00);
        n_cmp++; if (ack !== 1'b1 || arvalid !== 1'b1 || araddr !== 28'h184) begin n_bad++; $display("FAIL rst_pre: got %b/%b/%h want 1/1/184", ack, arvalid, araddr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ack !== 1'b0 || err !== 1'b0 || arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out: got %b/%b/%b want 0/0/0", ack, err, arvalid); end
        n_cmp++; if (wdata !== 32'h0 || araddr !== 28'h0) begin n_bad++; $display("FAIL rst_mid_data: got %h/%h want 0/0", wdata, araddr); end
        n_cmp++; if (dut.outstanding_r !== 4'd0 || dut.flushing_r !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state: got %0d/%b want 0/0", dut.outstanding_r, dut.flushing_r); end
        tick();
        rst_n = 1'b1; arready = 1'b1;
        tick();
        n_cmp++; if (arvalid !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rst_after: got %b/%b want 0/0", arvalid, stall); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_ar_backpressure();
        test_error_flush();
        test_cyc_drop();
        test_write_err();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
